ram_test_sequencer: RTL

RAM_TEST_SEQUENCER -- requirements
Module: ram_test_sequencer

---
 rtl/ram_test_sequencer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ram_test_sequencer.sv
// March-style RAM tester: writes a seeded pattern, reads it back, counts mismatches.
// Optional inverted second pass is enabled by defining RAM_TEST_SEQ_INVERT_PASS_EN.
module ram_test_sequencer #(
    parameter int BITWIDTH_IN  = 12,
    parameter int BITWIDTH_SYS = 16,
    parameter int BITWIDTH_ADR = 6,
    parameter int READ_LAT     = 1
) (
    input  logic                    CLK_SYS,
    input  logic                    RST,
    input  logic                    START,
    input  logic                    ABORT,
    input  logic [BITWIDTH_IN-1:0]  SEED,
    input  logic                    RDY_DUT,
    input  logic [BITWIDTH_SYS-1:0] RD_DATA,
    output logic                    EN,
    output logic                    RnW,
    output logic [BITWIDTH_ADR-1:0] ADR,
    output logic [BITWIDTH_SYS-1:0] WR_DATA,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    PASS,
    output logic [15:0]             ERR_CNT,
    output logic [BITWIDTH_ADR-1:0] FIRST_ERR_ADR
);

`ifdef RAM_TEST_SEQ_INVERT_PASS_EN
    localparam bit TWO_PASS = 1'b1;
`else
    localparam bit TWO_PASS = 1'b0;
`endif

    localparam logic [BITWIDTH_ADR-1:0] ADR_LAST = {BITWIDTH_ADR{1'b1}};
    localparam logic [2:0] DRAIN_LAST = 3'(READ_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t                  state_q;
    logic [BITWIDTH_ADR-1:0] adr_q;
    logic [BITWIDTH_IN-1:0]  seed_q;
    logic                    pass_idx_q;
    logic                    pass_q;
    logic [2:0]              drain_q;
    logic [15:0]             err_cnt_q;
    logic [15:0]             err_cnt_d;
    logic [BITWIDTH_ADR-1:0] first_err_q;

    logic [READ_LAT-1:0]     vld_q;
    logic [BITWIDTH_IN-1:0]  exp_q  [READ_LAT];
    logic [BITWIDTH_ADR-1:0] padr_q [READ_LAT];

    logic                    start_acc;
    logic                    issue;
    logic                    mism;
    logic [BITWIDTH_IN-1:0]  pat;
    logic [BITWIDTH_IN-1:0]  rd_top;
    logic                    unused_rd;

    assign start_acc = START && !ABORT && (state_q == S_IDLE);
    assign issue     = RDY_DUT && ((state_q == S_WRITE) || (state_q == S_READ));

    // Pattern for the current address; pass 1 uses the bitwise inverse.
    assign pat = (seed_q + BITWIDTH_IN'(adr_q)) ^ {BITWIDTH_IN{pass_idx_q}};

    assign rd_top    = RD_DATA[BITWIDTH_SYS-1 -: BITWIDTH_IN];
    assign unused_rd = ^RD_DATA;
    assign mism      = vld_q[READ_LAT-1] && (rd_top != exp_q[READ_LAT-1]);
    assign err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;

    assign EN            = issue;
    assign RnW           = (state_q == S_WRITE);
    assign ADR           = adr_q;
    assign WR_DATA       = (state_q == S_WRITE) ?
                           (BITWIDTH_SYS'(pat) << (BITWIDTH_SYS - BITWIDTH_IN)) : '0;
    assign BUSY          = (state_q != S_IDLE);
    assign DONE          = (state_q == S_FINISH);
    assign PASS          = pass_q;
    assign ERR_CNT       = err_cnt_q;
    assign FIRST_ERR_ADR = first_err_q;

    // Sequencing FSM: address walk, pass selection, drain and completion.
    always_ff @(posedge CLK_SYS or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            adr_q      <= '0;
            seed_q     <= '0;
            pass_idx_q <= 1'b0;
            pass_q     <= 1'b0;
            drain_q    <= '0;
        end else if (ABORT) begin
            state_q    <= S_IDLE;
            adr_q      <= '0;
            pass_idx_q <= 1'b0;
            pass_q     <= 1'b0;
            drain_q    <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (START) begin
                        seed_q     <= SEED;
                        adr_q      <= '0;
                        pass_idx_q <= 1'b0;
                        pass_q     <= 1'b0;
                        state_q    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (RDY_DUT) begin
                        if (adr_q == ADR_LAST) begin
                            adr_q   <= '0;
                            state_q <= S_READ;
                        end else begin
                            adr_q <= adr_q + BITWIDTH_ADR'(1);
                        end
                    end
                end
                S_READ: begin
                    if (RDY_DUT) begin
                        if (adr_q == ADR_LAST) begin
                            drain_q <= '0;
                            state_q <= S_DRAIN;
                        end else begin
                            adr_q <= adr_q + BITWIDTH_ADR'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        if (TWO_PASS && !pass_idx_q) begin
                            pass_idx_q <= 1'b1;
                            adr_q      <= '0;
                            state_q    <= S_WRITE;
                        end else begin
                            pass_q  <= (err_cnt_q == 16'd0) && !mism;
                            state_q <= S_FINISH;
                        end
                    end else begin
                        drain_q <= drain_q + 3'd1;
                    end
                end
                S_FINISH: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    // Read-compare pipeline and error bookkeeping.
    always_ff @(posedge CLK_SYS or posedge RST) begin
        if (RST) begin
            vld_q       <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                exp_q[i]  <= '0;
                padr_q[i] <= '0;
            end
        end else if (ABORT) begin
            vld_q <= '0;
        end else begin
            if (start_acc) begin
                err_cnt_q   <= '0;
                first_err_q <= '0;
            end else if (mism) begin
                err_cnt_q <= err_cnt_d;
                if (err_cnt_q == 16'd0) begin
                    first_err_q <= padr_q[READ_LAT-1];
                end
            end
            vld_q[0]  <= issue && (state_q == S_READ);
            exp_q[0]  <= pat;
            padr_q[0] <= adr_q;
            for (int i = 1; i < READ_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                exp_q[i]  <= exp_q[i-1];
                padr_q[i] <= padr_q[i-1];
            end
        end
    end

endmodule
